// File: rtl/div_iter_unit_pkg.sv
// Shared ALU operation codes for the divide/modulo unit and a helper to recognise them.
package div_iter_unit_pkg;

  localparam logic [7:0] ALU_DIVW  = 8'h20;
  localparam logic [7:0] ALU_DIVWU = 8'h21;
  localparam logic [7:0] ALU_MODW  = 8'h22;
  localparam logic [7:0] ALU_MODWU = 8'h23;

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == ALU_DIVW) || (op == ALU_DIVWU) || (op == ALU_MODW) || (op == ALU_MODWU);
  endfunction

  function automatic logic is_signed_op(input logic [7:0] op);
    return (op == ALU_DIVW) || (op == ALU_MODW);
  endfunction

  function automatic logic is_mod_op(input logic [7:0] op);
    return (op == ALU_MODW) || (op == ALU_MODWU);
  endfunction

endpackage

// File: rtl/div_iter_unit_div_restore_step.sv
// One radix-2 restoring division step: shift {rem,quo} left by one, trial-subtract the divisor.
module div_restore_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_rem,
  input  logic [W-1:0] i_quo,
  input  logic [W-1:0] i_divisor,
  output logic [W-1:0] o_rem,
  output logic [W-1:0] o_quo
);

  logic [W:0] w_shift;
  logic [W:0] w_diff;

  assign w_shift = {i_rem, i_quo[W-1]};
  // Bit W of the difference is the borrow: set when the shifted remainder is below the divisor.
  assign w_diff  = w_shift - {1'b0, i_divisor};
  assign o_rem   = w_diff[W] ? w_shift[W-1:0] : w_diff[W-1:0];
  assign o_quo   = {i_quo[W-2:0], ~w_diff[W]};

endmodule

// File: rtl/div_iter_unit.sv
// Multi-cycle 32-bit DIVW/DIVWU/MODW/MODWU unit (restoring, one op in flight).
// Optional DIV_EARLY_OUT_EN: skip the iterative phase when the quotient is trivially zero or the divisor is zero.
module div_iter_unit
  import div_iter_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        aluop,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic [31:0]       pc_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [TAG_W-1:0]  tag_out,
  output logic [31:0]       pc_out
);

  localparam int              CNT_W    = 6;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic              r_op_signed;
  logic              r_op_mod;
  logic [DATA_W-1:0] r_src1;
  logic [DATA_W-1:0] r_src2;
  logic              r_neg_quo;
  logic              r_neg_rem;
  logic              r_div_zero;
  logic [DATA_W-1:0] r_divisor;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_quo;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_result;
  logic [TAG_W-1:0]  r_tag_out;
  logic [31:0]       r_pc_out;

  logic              w_accept;
  logic              w_src1_neg;
  logic              w_src2_neg;
  logic [DATA_W-1:0] w_mag1;
  logic [DATA_W-1:0] w_mag2;
  logic              w_div_zero;
  logic              w_early;
  logic [DATA_W-1:0] w_step_rem;
  logic [DATA_W-1:0] w_step_quo;

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign tag_out   = r_tag_out;
  assign pc_out    = r_pc_out;

  assign w_accept   = in_valid && in_ready && is_div_op(aluop);
  assign w_src1_neg = r_op_signed && r_src1[DATA_W-1];
  assign w_src2_neg = r_op_signed && r_src2[DATA_W-1];
  assign w_mag1     = w_src1_neg ? -r_src1 : r_src1;
  assign w_mag2     = w_src2_neg ? -r_src2 : r_src2;
  assign w_div_zero = (r_src2 == '0);

`ifdef DIV_EARLY_OUT_EN
  assign w_early = w_div_zero || (w_mag1 < w_mag2);
`else
  assign w_early = 1'b0;
`endif

  div_restore_step #(.W(DATA_W)) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_divisor),
    .o_rem     (w_step_rem),
    .o_quo     (w_step_quo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = ST_PREP;
      ST_PREP: w_state_next = w_early ? ST_FIX : ST_CALC;
      ST_CALC: if (r_cnt == CNT_LAST) w_state_next = ST_FIX;
      ST_FIX:  w_state_next = ST_DONE;
      ST_DONE: if (out_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
    // Flush wins over any same-cycle accept or result transfer.
    if (flush) w_state_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_signed <= 1'b0;
      r_op_mod    <= 1'b0;
      r_src1      <= '0;
      r_src2      <= '0;
      r_neg_quo   <= 1'b0;
      r_neg_rem   <= 1'b0;
      r_div_zero  <= 1'b0;
      r_divisor   <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_tag_out   <= '0;
      r_pc_out    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && !flush) begin
            r_op_signed <= is_signed_op(aluop);
            r_op_mod    <= is_mod_op(aluop);
            r_src1      <= src1;
            r_src2      <= src2;
            r_tag_out   <= tag_in;
            r_pc_out    <= pc_in;
          end
        end
        ST_PREP: begin
          r_neg_quo  <= w_src1_neg ^ w_src2_neg;
          r_neg_rem  <= w_src1_neg;
          r_div_zero <= w_div_zero;
          r_divisor  <= w_mag2;
          r_cnt      <= '0;
          // Early exit leaves the quotient at zero and the whole dividend as remainder.
          if (w_early) begin
            r_quo <= '0;
            r_rem <= w_mag1;
          end else begin
            r_quo <= w_mag1;
            r_rem <= '0;
          end
        end
        ST_CALC: begin
          r_quo <= w_step_quo;
          r_rem <= w_step_rem;
          r_cnt <= r_cnt + 1'b1;
        end
        ST_FIX: begin
          if (r_div_zero) begin
            r_result <= r_op_mod ? r_src1 : '1;
          end else if (r_op_mod) begin
            r_result <= r_neg_rem ? -r_rem : r_rem;
          end else begin
            r_result <= r_neg_quo ? -r_quo : r_quo;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed self-checking bench for div_iter_unit: vector table plus handshake/flush/reset sequences.
module tb_div_iter_unit;
  import div_iter_unit_pkg::*;

  localparam int LAT_FULL = 34;
`ifdef DIV_EARLY_OUT_EN
  // Two edges after the accept edge, i.e. three edges counting the accept itself.
  localparam int LAT_EARLY = 2;
`else
  localparam int LAT_EARLY = 34;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  aluop;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [4:0]  tag_in;
  logic [31:0] pc_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  tag_out;
  logic [31:0] pc_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_iter_unit #(.DATA_W(32), .TAG_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluop     (aluop),
    .src1      (src1),
    .src2      (src2),
    .tag_in    (tag_in),
    .pc_in     (pc_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .tag_out   (tag_out),
    .pc_out    (pc_out)
  );

  typedef struct {
    string       name;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          early;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic [31:0] pc);
    @(negedge clk);
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    aluop    = op;
    src1     = a;
    src2     = b;
    tag_in   = tag;
    pc_in    = pc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    aluop    = 8'h00;
    check("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic watch_no_valid(input string name, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check(name, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] held_res;
    logic [4:0]  held_tag;
    logic [31:0] held_pc;

    vecs[0]  = '{"divw_m7_2",      ALU_DIVW,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0};
    vecs[1]  = '{"modw_m7_2",      ALU_MODW,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{"divwu_max_1",    ALU_DIVWU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 1'b0};
    vecs[3]  = '{"modwu_100_7",    ALU_MODWU, 32'd100,       32'd7,         32'd2,         1'b0};
    vecs[4]  = '{"divwu_7_100",    ALU_DIVWU, 32'd7,         32'd100,       32'd0,         1'b1};
    vecs[5]  = '{"divw_5_0",       ALU_DIVW,  32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[6]  = '{"modw_5_0",       ALU_MODW,  32'd5,         32'd0,         32'd5,         1'b1};
    vecs[7]  = '{"divw_min_m1",    ALU_DIVW,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0};
    vecs[8]  = '{"modw_min_m1",    ALU_MODW,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0};
    vecs[9]  = '{"divw_100_m7",    ALU_DIVW,  32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0};
    vecs[10] = '{"modw_100_m7",    ALU_MODW,  32'd100,       32'hFFFF_FFF9, 32'd2,         1'b0};
    vecs[11] = '{"modw_m100_7",    ALU_MODW,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 1'b0};
    vecs[12] = '{"divwu_min_max",  ALU_DIVWU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1};
    vecs[13] = '{"modwu_m7_0",     ALU_MODWU, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1'b1};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; aluop = 8'h00;
    src1 = '0; src2 = '0; tag_in = '0; pc_in = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready",  {31'd0, in_ready},  32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result",    result,             32'd0);
    check("reset_tag_out",   {27'd0, tag_out},   32'd0);
    check("reset_pc_out",    pc_out,             32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 14; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), 32'h100 + 32'(i * 4));
      wait_valid(lat);
      check({vecs[i].name, "_latency"}, 32'(lat), vecs[i].early ? 32'(LAT_EARLY) : 32'(LAT_FULL));
      check({vecs[i].name, "_result"},  result,   vecs[i].exp);
      check({vecs[i].name, "_tag"},     {27'd0, tag_out}, {27'd0, 5'(i + 1)});
      check({vecs[i].name, "_pc"},      pc_out,   32'h100 + 32'(i * 4));
      consume();
      check({vecs[i].name, "_idle_after"}, {31'd0, in_ready}, 32'd1);
      $display("op %-14s a=%h b=%h -> result=%h latency=%0d", vecs[i].name, vecs[i].a, vecs[i].b, result, lat);
    end

    // Unknown aluop is ignored: no accept, no result.
    @(negedge clk);
    in_valid = 1'b1; aluop = 8'h05; src1 = 32'd9; src2 = 32'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0; aluop = 8'h00;
    check("illegal_op_in_ready", {31'd0, in_ready}, 32'd1);
    watch_no_valid("illegal_op_no_valid", 40);
    $display("op illegal_aluop ignored");

    // Hold result in DONE with out_ready low.
    start_op(ALU_DIVW, 32'd9, 32'd3, 5'd7, 32'h0000_1000);
    wait_valid(lat);
    check("hold_latency", 32'(lat), 32'(LAT_FULL));
    held_res = result; held_tag = tag_out; held_pc = pc_out;
    check("hold_result_value", held_res, 32'd3);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("hold_result_stable", result, held_res);
      check("hold_tag_stable",    {27'd0, tag_out}, {27'd0, held_tag});
      check("hold_pc_stable",     pc_out, held_pc);
      check("hold_in_ready_low",  {31'd0, in_ready}, 32'd0);
      check("hold_out_valid",     {31'd0, out_valid}, 32'd1);
    end
    consume();
    check("hold_release_in_ready",  {31'd0, in_ready},  32'd1);
    check("hold_release_out_valid", {31'd0, out_valid}, 32'd0);
    $display("op hold_done result=%h tag=%h pc=%h", held_res, held_tag, held_pc);

    // Flush in the middle of the iterative phase.
    start_op(ALU_DIVW, 32'd1000, 32'd7, 5'd3, 32'h0000_2000);
    repeat (12) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_in_ready_next", {31'd0, in_ready}, 32'd1);
    watch_no_valid("flush_no_valid", 40);
    start_op(ALU_DIVW, 32'd9, 32'd3, 5'd4, 32'h0000_2004);
    wait_valid(lat);
    check("after_flush_latency", 32'(lat), 32'(LAT_FULL));
    check("after_flush_result",  result,   32'd3);
    consume();
    $display("op flush_then_divw_9_3 result=%h", result);

    // Back-to-back: offered on the transfer cycle is refused, accepted on the next.
    start_op(ALU_DIVWU, 32'd50, 32'd5, 5'd9, 32'h0000_3000);
    wait_valid(lat);
    check("b2b_first_result", result, 32'd10);
    out_ready = 1'b1;
    in_valid = 1'b1; aluop = ALU_DIVW; src1 = 32'd20; src2 = 32'd4; tag_in = 5'd10; pc_in = 32'h0000_3004;
    check("b2b_in_ready_on_transfer", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("b2b_in_ready_after_transfer", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; aluop = 8'h00;
    check("b2b_accepted_second", {31'd0, in_ready}, 32'd0);
    wait_valid(lat);
    check("b2b_second_latency", 32'(lat), 32'(LAT_FULL));
    check("b2b_second_result",  result,   32'd5);
    check("b2b_second_tag",     {27'd0, tag_out}, 32'd10);
    consume();
    $display("op back_to_back second result=%h", result);

    // Asynchronous reset in the middle of an op.
    start_op(ALU_DIVW, 32'd77, 32'd7, 5'd12, 32'h0000_4000);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_result",    result,             32'd0);
    check("async_rst_tag",       {27'd0, tag_out},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_valid("async_rst_no_valid", 40);
    $display("op async_reset_mid_op");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
